// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Optional: define MDU_MADD_EN to accept MADD (op 7) and MADDU (op 8) accumulate ops.
module mdu_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
`endif

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [3:0]  count_reg, count_next;
   logic [63:0] pend_reg, pend_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;
   logic        busy_reg, busy_next;

   // Multiplier: both products are formed; the decoder picks one.
   logic signed [63:0] a_sx, b_sx, prod_s;
   logic        [63:0] prod_u;

   assign a_sx   = {{32{a[31]}}, a};
   assign b_sx   = {{32{b[31]}}, b};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Divider works on magnitudes so that INT_MIN / -1 wraps cleanly to INT_MIN.
   logic        div_signed, div_by_zero;
   logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quot, rem;

   assign div_signed  = (op == OP_DIV);
   assign div_by_zero = (b == 32'd0);
   assign dvd         = (div_signed && a[31]) ? (32'd0 - a) : a;
   assign dvs         = (div_signed && b[31]) ? (32'd0 - b) : b;
   assign dvs_safe    = div_by_zero ? 32'd1 : dvs;
   assign q_mag       = dvd / dvs_safe;
   assign r_mag       = dvd % dvs_safe;
   assign quot        = (div_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
   assign rem         = (div_signed && a[31]) ? (32'd0 - r_mag) : r_mag;

   logic        is_mul, is_div, is_mthi, is_mtlo;
   logic [63:0] mul_result;

   always_comb begin
      is_mul     = 1'b0;
      is_div     = 1'b0;
      is_mthi    = 1'b0;
      is_mtlo    = 1'b0;
      mul_result = prod_u;
      case (op)
         OP_MULT: begin
            is_mul     = 1'b1;
            mul_result = prod_s;
         end
         OP_MULTU:        is_mul  = 1'b1;
         OP_DIV, OP_DIVU: is_div  = 1'b1;
         OP_MTHI:         is_mthi = 1'b1;
         OP_MTLO:         is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
         // Accumulate into the HI/LO value present at the start edge, mod 2^64.
         OP_MADD: begin
            is_mul     = 1'b1;
            mul_result = {hi_reg, lo_reg} + prod_s;
         end
         OP_MADDU: begin
            is_mul     = 1'b1;
            mul_result = {hi_reg, lo_reg} + prod_u;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      pend_next  = pend_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      busy_next  = busy_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (is_mul) begin
                  pend_next  = mul_result;
                  count_next = MULT_LOAD;
                  busy_next  = 1'b1;
                  state_next = BUSY;
               end else if (is_div) begin
                  // A zero divisor commits the current HI/LO back unchanged.
                  pend_next  = div_by_zero ? {hi_reg, lo_reg} : {rem, quot};
                  count_next = DIV_LOAD;
                  busy_next  = 1'b1;
                  state_next = BUSY;
               end else if (is_mthi) begin
                  hi_next = a;
               end else if (is_mtlo) begin
                  lo_next = a;
               end
            end
         end
         BUSY: begin
            count_next = count_reg - 4'd1;
            if (count_reg == 4'd1) begin
               hi_next    = pend_reg[63:32];
               lo_next    = pend_reg[31:0];
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         count_reg <= 4'd0;
         pend_reg  <= 64'd0;
         hi_reg    <= 32'd0;
         lo_reg    <= 32'd0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         pend_reg  <= pend_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
         busy_reg  <= busy_next;
      end
   end

   assign busy = busy_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops against a behavioural HI/LO model.
// Honours MDU_MADD_EN the same way as the design.
module tb_mdu_unit;

   localparam int MC = 5;
   localparam int DC = 10;
`ifdef MDU_MADD_EN
   localparam bit MADD_ON = 1'b1;
`else
   localparam bit MADD_ON = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op    = 4'd0;
   logic [31:0] a     = 32'd0;
   logic [31:0] b     = 32'd0;
   logic        busy;
   logic [31:0] hi, lo;

   int pass_count  = 0;
   int check_count = 0;

   always #5 clk = ~clk;

   mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   function automatic int latency(input logic [3:0] o);
      case (o)
         4'd1, 4'd2: return MC;
         4'd3, 4'd4: return DC;
         4'd7, 4'd8: return MADD_ON ? MC : 0;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] hilo);
      longint      sx, sy, q, rm;
      logic [63:0] r;
      sx = $signed(x);
      sy = $signed(y);
      r  = hilo;
      case (o)
         4'd1: r = sx * sy;
         4'd2: r = {32'd0, x} * {32'd0, y};
         4'd3: if (y != 32'd0) begin
            q  = sx / sy;
            rm = sx % sy;
            r  = {rm[31:0], q[31:0]};
         end
         4'd4: if (y != 32'd0) r = {x % y, x / y};
         4'd7: r = hilo + 64'(sx * sy);
         4'd8: r = hilo + {32'd0, x} * {32'd0, y};
         default: r = hilo;
      endcase
      return r;
   endfunction

   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic [63:0] m_pend = 64'd0;
   logic        m_pending = 1'b0;
   int          m_edges = 0;
   int          m_due = 0;

   // Result becomes architectural exactly latency edges after the accepting edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi      <= 32'd0;
         m_lo      <= 32'd0;
         m_pending <= 1'b0;
      end else begin
         m_edges <= m_edges + 1;
         if (m_pending) begin
            if (m_edges + 1 == m_due) begin
               m_hi      <= m_pend[63:32];
               m_lo      <= m_pend[31:0];
               m_pending <= 1'b0;
            end
         end else if (start) begin
            if (latency(op) != 0) begin
               m_pend    <= ref_result(op, a, b, {m_hi, m_lo});
               m_due     <= m_edges + 1 + latency(op);
               m_pending <= 1'b1;
               $display("txn accept op=%0d a=%h b=%h", op, a, b);
            end else if (op == 4'd5) m_hi <= a;
            else if (op == 4'd6) m_lo <= a;
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_busy", 64'(busy), 64'(m_pending));
      chk("cyc_hi", 64'(hi), 64'(m_hi));
      chk("cyc_lo", 64'(lo), 64'(m_lo));
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      op    = 4'd0;
   endtask

   task automatic run_busy(input string name, input int exp_n, input int pulse_at,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int          n;
      logic [63:0] hold;
      n    = 0;
      hold = {hi, lo};
      while (busy && n < 40) begin
         if (n == pulse_at) begin
            start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd3;
         end else begin
            start = 1'b0; op = 4'd0;
         end
         chk({name, "_hold"}, {hi, lo}, hold);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      op    = 4'd0;
      chk({name, "_cycles"}, 64'(n), 64'(exp_n));
      chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
      chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
      $display("txn %s: busy %0d cycles hi=%h lo=%h", name, n, hi, lo);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);

      issue(4'd1, 32'hFFFF_FFFD, 32'd5);
      run_busy("mult", 5, -1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      issue(4'd2, 32'hFFFF_FFFF, 32'd2);
      run_busy("multu", 5, -1, 32'h0000_0001, 32'hFFFF_FFFE);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      run_busy("div_neg", 10, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_busy("div_ovf", 10, -1, 32'h0000_0000, 32'h8000_0000);

      issue(4'd5, 32'h1111_1111, 32'd0);
      chk("mthi_busy", 64'(busy), 64'd0);
      chk("mthi_hi", 64'(hi), 64'h1111_1111);
      issue(4'd6, 32'h2222_2222, 32'd0);
      chk("mtlo_busy", 64'(busy), 64'd0);
      chk("mtlo_lo", 64'(lo), 64'h2222_2222);
      $display("txn mthi/mtlo: hi=%h lo=%h", hi, lo);

      issue(4'd4, 32'd7, 32'd0);
      run_busy("divu_zero", 10, -1, 32'h1111_1111, 32'h2222_2222);

      issue(4'd3, 32'd100, 32'd7);
      run_busy("div_pulse", 10, 2, 32'd2, 32'd14);

      issue(4'd5, 32'd0, 32'd0);
      issue(4'd6, 32'hFFFF_FFFF, 32'd0);
      issue(4'd8, 32'd1, 32'd1);
      run_busy("maddu", MADD_ON ? 5 : 0, -1,
               MADD_ON ? 32'd1 : 32'd0, MADD_ON ? 32'd0 : 32'hFFFF_FFFF);

      // Asynchronous reset in busy cycle 4 of a MULT.
      issue(4'd1, 32'd7, 32'd9);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_hilo", {hi, lo}, 64'd0);
      #1 reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("no_late_commit", {hi, lo}, 64'd0);
      $display("txn reset mid-mult: busy=%0d hi=%h lo=%h", busy, hi, lo);

      for (int i = 0; i < 800; i++) begin
         start = ($urandom_range(0, 2) == 0);
         op    = 4'($urandom_range(0, 9));
         a     = $urandom;
         b     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 15) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         @(negedge clk);
      end
      start = 1'b0;
      op    = 4'd0;
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
      chk("final_idle", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
